// File: rtl/can_rx_sequencer.sv
// CAN receive sequencer: bit timing recovery, destuffing and frame framing that
// drives the restart/enable/data inputs of the packet-capture datapath.
module can_rx_sequencer #(
  parameter int CLK_PER_BIT = 16,
  parameter int SAMPLE_PT   = 11,
  parameter int SJW         = 2,
  parameter int IDLE_BITS   = 11,
  parameter int EOF_BITS    = 7
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  input  logic       destuff_off,
  output logic       cap_rst,
  output logic       cap_en,
  output logic       cap_rx,
  output logic       frame_active,
  output logic       frame_done,
  output logic       stuff_err,
  output logic [7:0] bit_cnt
);

  localparam int PW      = $clog2(CLK_PER_BIT);
  localparam int RUN_MAX = (IDLE_BITS > EOF_BITS) ? IDLE_BITS : EOF_BITS;
  localparam int RW      = $clog2(RUN_MAX + 1);

  typedef enum logic [2:0] {
    INTEGRATE,
    IDLE,
    SOF_CHK,
    RX,
    TAIL,
    ERROR
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   phase, phase_nxt;
  logic            rx_prev;
  logic            resynced, resynced_nxt;
  logic [RW-1:0]   run_cnt, run_nxt;
  logic            stuff_val, sval_nxt;
  logic [2:0]      stuff_run, srun_nxt;

  logic            cap_rst_nxt, cap_en_nxt, cap_rx_nxt;
  logic            frame_active_nxt, frame_done_nxt, stuff_err_nxt;
  logic [7:0]      bit_cnt_nxt;

  logic            sample_pt, fall, hard_sync, resync;

  assign sample_pt = (phase == PW'(SAMPLE_PT));
  assign fall      = rx_prev & ~rx;
  assign hard_sync = (state == IDLE) && fall;
  assign resync    = ((state == SOF_CHK) || (state == RX) || (state == TAIL)) &&
                     fall && (phase != '0) && !sample_pt && !resynced;

  // Phase corrections are applied on top of the normal one-count advance.
  always_comb begin
    int e, d, p;
    e            = int'(phase);
    d            = 0;
    p            = 0;
    phase_nxt    = (phase == PW'(CLK_PER_BIT - 1)) ? '0 : phase + PW'(1);
    resynced_nxt = sample_pt ? 1'b0 : resynced;
    if (hard_sync) begin
      phase_nxt = '0;
    end else if (resync) begin
      resynced_nxt = 1'b1;
      if (e < SAMPLE_PT) begin
        d = (e < SJW) ? e : SJW;
        p = e + 1 - d;
      end else begin
        d = ((CLK_PER_BIT - e) < SJW) ? (CLK_PER_BIT - e) : SJW;
        p = e + 1 + d;
        if (p >= CLK_PER_BIT) p = p - CLK_PER_BIT;
      end
      phase_nxt = PW'(p);
    end
  end

  always_comb begin
    state_nxt        = state;
    cap_rst_nxt      = cap_rst;
    cap_en_nxt       = 1'b0;
    cap_rx_nxt       = cap_rx;
    frame_active_nxt = frame_active;
    frame_done_nxt   = 1'b0;
    stuff_err_nxt    = 1'b0;
    bit_cnt_nxt      = bit_cnt;
    run_nxt          = run_cnt;
    sval_nxt         = stuff_val;
    srun_nxt         = stuff_run;

    case (state)
      INTEGRATE: begin
        cap_rst_nxt      = 1'b1;
        frame_active_nxt = 1'b0;
        if (sample_pt) begin
          if (!rx) begin
            run_nxt = '0;
          end else if (run_cnt == RW'(IDLE_BITS - 1)) begin
            run_nxt   = '0;
            state_nxt = IDLE;
          end else begin
            run_nxt = run_cnt + RW'(1);
          end
        end
      end

      IDLE: begin
        cap_rst_nxt = 1'b1;
        if (hard_sync) state_nxt = SOF_CHK;
      end

      SOF_CHK: begin
        if (sample_pt) begin
          if (!rx) begin
            state_nxt        = RX;
            cap_rst_nxt      = 1'b0;
            frame_active_nxt = 1'b1;
            bit_cnt_nxt      = '0;
            sval_nxt         = 1'b0;
            srun_nxt         = 3'd1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end

      // A stuff bit is whatever follows five equal bits; destuff_off only
      // takes effect from the next bit, so an error here still wins.
      RX: begin
        if (sample_pt) begin
          if (stuff_run == 3'd5) begin
            if (rx == stuff_val) begin
              stuff_err_nxt    = 1'b1;
              frame_active_nxt = 1'b0;
              cap_rst_nxt      = 1'b1;
              state_nxt        = ERROR;
            end else begin
              sval_nxt = rx;
              srun_nxt = 3'd1;
            end
          end else begin
            cap_en_nxt  = 1'b1;
            cap_rx_nxt  = rx;
            bit_cnt_nxt = (bit_cnt == 8'hFF) ? bit_cnt : bit_cnt + 8'd1;
            if (rx == stuff_val) begin
              srun_nxt = stuff_run + 3'd1;
            end else begin
              sval_nxt = rx;
              srun_nxt = 3'd1;
            end
          end
          if (destuff_off && (state_nxt == RX)) begin
            state_nxt = TAIL;
            run_nxt   = '0;
          end
        end
      end

      // frame_done follows the last cap_en by one clk so they never coincide.
      TAIL: begin
        if (run_cnt == RW'(EOF_BITS)) begin
          frame_done_nxt   = 1'b1;
          frame_active_nxt = 1'b0;
          cap_rst_nxt      = 1'b1;
          run_nxt          = '0;
          state_nxt        = IDLE;
        end else if (sample_pt) begin
          cap_en_nxt  = 1'b1;
          cap_rx_nxt  = rx;
          bit_cnt_nxt = (bit_cnt == 8'hFF) ? bit_cnt : bit_cnt + 8'd1;
          run_nxt     = rx ? run_cnt + RW'(1) : '0;
        end
      end

      ERROR: begin
        frame_active_nxt = 1'b0;
        cap_rst_nxt      = 1'b1;
        run_nxt          = '0;
        state_nxt        = INTEGRATE;
      end

      default: state_nxt = INTEGRATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= INTEGRATE;
      phase        <= '0;
      rx_prev      <= 1'b1;
      resynced     <= 1'b0;
      run_cnt      <= '0;
      stuff_val    <= 1'b0;
      stuff_run    <= 3'd1;
      cap_rst      <= 1'b1;
      cap_en       <= 1'b0;
      cap_rx       <= 1'b1;
      frame_active <= 1'b0;
      frame_done   <= 1'b0;
      stuff_err    <= 1'b0;
      bit_cnt      <= '0;
    end else begin
      state        <= state_nxt;
      phase        <= phase_nxt;
      rx_prev      <= rx;
      resynced     <= resynced_nxt;
      run_cnt      <= run_nxt;
      stuff_val    <= sval_nxt;
      stuff_run    <= srun_nxt;
      cap_rst      <= cap_rst_nxt;
      cap_en       <= cap_en_nxt;
      cap_rx       <= cap_rx_nxt;
      frame_active <= frame_active_nxt;
      frame_done   <= frame_done_nxt;
      stuff_err    <= stuff_err_nxt;
      bit_cnt      <= bit_cnt_nxt;
    end
  end

endmodule

// File: tb/tb_can_rx_sequencer.sv
// Bench for can_rx_sequencer: a bit-level CAN transmitter with its own stuffing
// model drives rx; captured bits are compared against the unstuffed payload.
module tb_can_rx_sequencer;

  localparam int PER       = 16;
  localparam int IDLE_BITS = 11;
  localparam int EOF_BITS  = 7;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       destuff_off = 1'b0;
  logic       cap_rst, cap_en, cap_rx, frame_active, frame_done, stuff_err;
  logic [7:0] bit_cnt;

  int checks   = 0;
  int failures = 0;

  bit cap_q[$];
  int last_cnt = 0;
  int n_err    = 0;
  int n_done   = 0;
  int n_excl   = 0;

  can_rx_sequencer #(
    .CLK_PER_BIT(16), .SAMPLE_PT(11), .SJW(2), .IDLE_BITS(IDLE_BITS), .EOF_BITS(EOF_BITS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .destuff_off(destuff_off),
    .cap_rst(cap_rst), .cap_en(cap_en), .cap_rx(cap_rx),
    .frame_active(frame_active), .frame_done(frame_done),
    .stuff_err(stuff_err), .bit_cnt(bit_cnt)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (cap_en === 1'b1) begin
      cap_q.push_back(cap_rx);
      last_cnt <= int'(bit_cnt);
    end
    if (stuff_err === 1'b1) n_err <= n_err + 1;
    if (frame_done === 1'b1) n_done <= n_done + 1;
    if ((cap_en && (stuff_err || frame_done)) || (stuff_err && frame_done)) n_excl <= n_excl + 1;
  end

  // Transmitter-side stuffing: after five equal bits (SOF included) insert the complement.
  function automatic void stuff_bits(input bit pay[$], output bit raw[$]);
    bit last = 1'b0;
    int run  = 1;
    raw.delete();
    foreach (pay[i]) begin
      if (run == 5) begin
        raw.push_back(!last);
        last = !last;
        run  = 1;
      end
      raw.push_back(pay[i]);
      if (pay[i] == last) run++;
      else begin
        last = pay[i];
        run  = 1;
      end
    end
  endfunction

  function automatic int first_diff(input int start, input bit exp[$]);
    for (int i = 0; i < exp.size(); i++)
      if ((start + i) >= cap_q.size() || cap_q[start + i] != exp[i]) return i;
    return -1;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input bit b, input int per);
    rx = b;
    tick(per);
  endtask

  task automatic hw_reset();
    rst_n = 1'b0;
    rx = 1'b1;
    destuff_off = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic go_idle();
    repeat (IDLE_BITS + 2) send_bit(1'b1, PER);
  endtask

  task automatic send_frame(input bit pay[$], input int per, input bit with_tail);
    bit raw[$];
    stuff_bits(pay, raw);
    send_bit(1'b0, per);
    for (int i = 0; i < raw.size(); i++) begin
      if (with_tail && i == raw.size() - 1) destuff_off = 1'b1;
      send_bit(raw[i], per);
    end
    if (with_tail) begin
      repeat (EOF_BITS + 1) send_bit(1'b1, per);
      destuff_off = 1'b0;
    end
  endtask

  task automatic rand_payload(input int n, output bit pay[$]);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(bit'($urandom_range(0, 1)));
  endtask

  task automatic test_reset();
    int s0;
    rst_n = 1'b0;
    rx = 1'b1;
    destuff_off = 1'b0;
    tick(2);
    @(negedge clk);
    checks++;
    if ({cap_rst, cap_en, cap_rx, frame_active, frame_done, stuff_err, bit_cnt} !== {6'b101000, 8'd0}) begin
      failures++;
      $display("FAIL reset_values got=%b exp=%b",
               {cap_rst, cap_en, cap_rx, frame_active, frame_done, stuff_err, bit_cnt}, {6'b101000, 8'd0});
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    s0 = cap_q.size();
    go_idle();
    @(negedge clk);
    checks++;
    if ({cap_rst, frame_active, 1'(cap_q.size() - s0)} !== 3'b100) begin
      failures++;
      $display("FAIL idle_quiet got cap_rst=%b active=%b pulses=%0d exp 1,0,0", cap_rst, frame_active, cap_q.size() - s0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    bit pay[$];
    int s0, e0, k;
    pay = '{1, 0, 1, 0, 1, 1, 0, 0};
    hw_reset();
    go_idle();
    s0 = cap_q.size();
    e0 = n_err;
    send_frame(pay, PER, 1'b0);
    @(negedge clk);
    checks++;
    if (cap_q.size() - s0 !== 8) begin
      failures++;
      $display("FAIL basic_pulses got=%0d exp=8", cap_q.size() - s0);
    end
    k = first_diff(s0, pay);
    checks++;
    if (k !== -1) begin
      failures++;
      $display("FAIL basic_data first bad index got=%0d exp=-1", k);
    end
    checks++;
    if (bit_cnt !== 8'd8) begin
      failures++;
      $display("FAIL basic_bit_cnt got=%0d exp=8", bit_cnt);
    end
    checks++;
    if ({frame_active, cap_rst} !== 2'b10 || n_err !== e0) begin
      failures++;
      $display("FAIL basic_active got active=%b cap_rst=%b errs=%0d exp 1,0,0", frame_active, cap_rst, n_err - e0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stuff();
    bit pay[$];
    int s0, e0, k;
    pay = '{0, 0, 0, 0, 1};
    hw_reset();
    go_idle();
    s0 = cap_q.size();
    e0 = n_err;
    send_frame(pay, PER, 1'b0);
    @(negedge clk);
    checks++;
    if (cap_q.size() - s0 !== 5 || n_err !== e0) begin
      failures++;
      $display("FAIL stuff_pulses got=%0d errs=%0d exp=5 errs=0", cap_q.size() - s0, n_err - e0);
    end
    k = first_diff(s0, pay);
    checks++;
    if (k !== -1) begin
      failures++;
      $display("FAIL stuff_data first bad index got=%0d exp=-1", k);
    end
    checks++;
    if (bit_cnt !== 8'd5) begin
      failures++;
      $display("FAIL stuff_bit_cnt got=%0d exp=5", bit_cnt);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_stuff_err();
    int s0, e0;
    hw_reset();
    go_idle();
    s0 = cap_q.size();
    e0 = n_err;
    send_bit(1'b0, PER);
    repeat (6) send_bit(1'b0, PER);
    @(negedge clk);
    checks++;
    if (n_err - e0 !== 1 || cap_q.size() - s0 !== 4) begin
      failures++;
      $display("FAIL stuff_err_count got errs=%0d pulses=%0d exp errs=1 pulses=4", n_err - e0, cap_q.size() - s0);
    end
    checks++;
    if ({frame_active, cap_rst} !== 2'b01) begin
      failures++;
      $display("FAIL stuff_err_abort got active=%b cap_rst=%b exp 0,1", frame_active, cap_rst);
    end
    @(posedge clk);
    #1;
    s0 = cap_q.size();
    repeat (3) send_bit(1'b1, PER);
    send_bit(1'b0, PER);
    send_bit(1'b1, PER);
    send_bit(1'b0, PER);
    @(negedge clk);
    checks++;
    if (cap_q.size() - s0 !== 0 || cap_rst !== 1'b1) begin
      failures++;
      $display("FAIL stuff_err_integrate got pulses=%0d cap_rst=%b exp 0,1", cap_q.size() - s0, cap_rst);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_tail();
    bit pay[$], exp[$], nxt[$];
    int s0, d0, e0, k;
    hw_reset();
    go_idle();
    rand_payload(int'($urandom_range(8, 20)), pay);
    exp = pay;
    repeat (EOF_BITS) exp.push_back(1'b1);
    s0 = cap_q.size();
    d0 = n_done;
    e0 = n_err;
    send_frame(pay, PER, 1'b1);
    @(negedge clk);
    checks++;
    if (cap_q.size() - s0 !== exp.size() || last_cnt !== exp.size()) begin
      failures++;
      $display("FAIL tail_pulses got=%0d cnt=%0d exp=%0d", cap_q.size() - s0, last_cnt, exp.size());
    end
    k = first_diff(s0, exp);
    checks++;
    if (k !== -1) begin
      failures++;
      $display("FAIL tail_data first bad index got=%0d exp=-1", k);
    end
    checks++;
    if (n_done - d0 !== 1 || n_err !== e0 || {frame_active, cap_rst} !== 2'b01) begin
      failures++;
      $display("FAIL tail_done got done=%0d errs=%0d active=%b cap_rst=%b exp 1,0,0,1",
               n_done - d0, n_err - e0, frame_active, cap_rst);
    end
    @(posedge clk);
    #1;
    nxt = '{1, 0, 1};
    s0 = cap_q.size();
    send_frame(nxt, PER, 1'b0);
    k = first_diff(s0, nxt);
    checks++;
    if (cap_q.size() - s0 !== 3 || k !== -1) begin
      failures++;
      $display("FAIL tail_next_sof got pulses=%0d bad=%0d exp 3,-1", cap_q.size() - s0, k);
    end
  endtask

  task automatic test_back_to_back();
    bit pay[$], exp[$];
    int s0, d0, e0, k;
    hw_reset();
    go_idle();
    for (int f = 0; f < 5; f++) begin
      rand_payload(int'($urandom_range(1, 40)), pay);
      exp = pay;
      repeat (EOF_BITS) exp.push_back(1'b1);
      s0 = cap_q.size();
      d0 = n_done;
      e0 = n_err;
      send_frame(pay, PER, 1'b1);
      k = first_diff(s0, exp);
      checks++;
      if (cap_q.size() - s0 !== exp.size() || k !== -1 || last_cnt !== exp.size()) begin
        failures++;
        $display("FAIL b2b_frame%0d got pulses=%0d bad=%0d cnt=%0d exp pulses=%0d bad=-1", f,
                 cap_q.size() - s0, k, last_cnt, exp.size());
      end
      checks++;
      if (n_done - d0 !== 1 || n_err !== e0) begin
        failures++;
        $display("FAIL b2b_done%0d got done=%0d errs=%0d exp 1,0", f, n_done - d0, n_err - e0);
      end
    end
  endtask

  task automatic test_drift();
    bit pay[$];
    int s0, e0, k;
    hw_reset();
    go_idle();
    pay.delete();
    for (int i = 0; i < 20; i++) pay.push_back(bit'(~i[0]));
    s0 = cap_q.size();
    e0 = n_err;
    send_frame(pay, PER + 1, 1'b0);
    k = first_diff(s0, pay);
    checks++;
    if (cap_q.size() - s0 !== 20 || k !== -1 || n_err !== e0) begin
      failures++;
      $display("FAIL drift17 got pulses=%0d bad=%0d errs=%0d exp 20,-1,0", cap_q.size() - s0, k, n_err - e0);
    end
  endtask

  task automatic test_saturate();
    bit pay[$];
    int s0, d0;
    hw_reset();
    go_idle();
    rand_payload(260, pay);
    s0 = cap_q.size();
    d0 = n_done;
    send_frame(pay, PER, 1'b1);
    checks++;
    if (cap_q.size() - s0 !== 260 + EOF_BITS || last_cnt !== 255 || n_done - d0 !== 1) begin
      failures++;
      $display("FAIL saturate got pulses=%0d cnt=%0d done=%0d exp %0d,255,1",
               cap_q.size() - s0, last_cnt, n_done - d0, 260 + EOF_BITS);
    end
  endtask

  task automatic test_midframe_reset();
    bit pre[$], pay[$], exp[$];
    int s0, d0, k;
    hw_reset();
    go_idle();
    d0 = n_done;
    pre = '{1, 0, 1, 1};
    send_frame(pre, PER, 1'b0);
    checks++;
    if (bit_cnt !== 8'd4 || frame_active !== 1'b1) begin
      failures++;
      $display("FAIL midreset_pre got cnt=%0d active=%b exp 4,1", bit_cnt, frame_active);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if ({cap_rst, cap_en, cap_rx, frame_active, frame_done, stuff_err, bit_cnt} !== {6'b101000, 8'd0}) begin
      failures++;
      $display("FAIL midreset_values got=%b exp=%b",
               {cap_rst, cap_en, cap_rx, frame_active, frame_done, stuff_err, bit_cnt}, {6'b101000, 8'd0});
    end
    @(posedge clk);
    #1;
    rx = 1'b1;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    go_idle();
    checks++;
    if (n_done !== d0) begin
      failures++;
      $display("FAIL midreset_no_done got=%0d exp=0", n_done - d0);
    end
    rand_payload(8, pay);
    exp = pay;
    repeat (EOF_BITS) exp.push_back(1'b1);
    s0 = cap_q.size();
    send_frame(pay, PER, 1'b1);
    k = first_diff(s0, exp);
    checks++;
    if (cap_q.size() - s0 !== exp.size() || k !== -1 || last_cnt !== 8 + EOF_BITS || n_done - d0 !== 1) begin
      failures++;
      $display("FAIL midreset_recover got pulses=%0d bad=%0d cnt=%0d done=%0d exp %0d,-1,%0d,1",
               cap_q.size() - s0, k, last_cnt, n_done - d0, exp.size(), 8 + EOF_BITS);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stuff();
    test_stuff_err();
    test_tail();
    test_back_to_back();
    test_drift();
    test_saturate();
    test_midframe_reset();
    checks++;
    if (n_excl !== 0) begin
      failures++;
      $display("FAIL exclusive_pulses got=%0d exp=0", n_excl);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
